// File: rtl/forward_ew_buffered.sv
// forward_ew_buffered: circular FIFO front end for the forward east/west path.
// Packets are queued in arrival order. The head packet is decoded and issued
// on exactly one of three registered output ports:
//   a : dx != 0, carried on with dx replaced by dx+ADD
//   b : dx == 0 and dy >= 0, dx field stripped
//   c : dx == 0 and dy <  0, dx field stripped
//
// Handshake (all ports): wen_x is a single-cycle write strobe qualifying
// dout_x. full_x is sampled in the cycle the head is popped; the write
// appears on the following cycle, so a downstream buffer must assert full_x
// while it still has one free entry. A blocked head stalls the whole queue.
module forward_ew_buffered #(
   parameter int DATA_WIDTH   = 32,
   parameter int DX_MSB       = 29,
   parameter int DX_LSB       = 21,
   parameter int DY_MSB       = 20,
   parameter int DY_LSB       = 12,
   parameter int ADD          = 1,
   parameter int BUFFER_DEPTH = 4
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [DATA_WIDTH-1:0]                         din,
   input  logic                                          din_wen,
   output logic                                          buffer_full,
   output logic                                          overflow,
   output logic [DATA_WIDTH-1:0]                         dout_a,
   output logic                                          wen_a,
   input  logic                                          full_a,
   output logic [DATA_WIDTH-(DX_MSB-DX_LSB+1)-1:0]       dout_b,
   output logic                                          wen_b,
   input  logic                                          full_b,
   output logic [DATA_WIDTH-(DX_MSB-DX_LSB+1)-1:0]       dout_c,
   output logic                                          wen_c,
   input  logic                                          full_c
);

   localparam int DXW = DX_MSB - DX_LSB + 1;
   localparam int DYW = DY_MSB - DY_LSB + 1;
   localparam int OW  = DATA_WIDTH - DXW;
   localparam int AW  = $clog2(BUFFER_DEPTH);

   localparam logic [DXW-1:0] ADD_V   = DXW'(ADD);
   localparam logic [AW:0]    DEPTH_V = (AW+1)'(BUFFER_DEPTH);

   typedef enum logic [1:0] {
      TGT_A = 2'd0,
      TGT_B = 2'd1,
      TGT_C = 2'd2
   } tgt_e;

   // Storage and pointers
   logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
   logic [AW-1:0]         wptr_q, wptr_d;
   logic [AW-1:0]         rptr_q, rptr_d;
   logic [AW:0]           count_q, count_d;
   logic                  overflow_q, overflow_d;

   // Output registers
   logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d;
   logic [OW-1:0]         dout_b_q, dout_b_d;
   logic [OW-1:0]         dout_c_q, dout_c_d;
   logic                  wen_a_q, wen_a_d;
   logic                  wen_b_q, wen_b_d;
   logic                  wen_c_q, wen_c_d;

   // Head decode
   logic [DATA_WIDTH-1:0] head;
   logic [DXW-1:0]        head_dx;
   logic [DYW-1:0]        head_dy;
   tgt_e                  head_tgt;
   logic                  tgt_full;
   logic [DATA_WIDTH-1:0] head_adj;
   logic [OW-1:0]         head_strip;

   // Queue control
   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;

   // Status flags come from the registered count only.
   assign fifo_full  = (count_q == DEPTH_V);
   assign fifo_empty = (count_q == '0);

   // Decode the head entry: pick its target port and whether that port is blocked.
   always_comb begin
      head     = mem_q[rptr_q];
      head_dx  = head[DX_MSB:DX_LSB];
      head_dy  = head[DY_MSB:DY_LSB];
      head_tgt = TGT_B;
      if (head_dx != '0) begin
         head_tgt = TGT_A;
      end else if ($signed(head_dy) < 0) begin
         head_tgt = TGT_C;
      end
      tgt_full = 1'b0;
      case (head_tgt)
         TGT_A:   tgt_full = full_a;
         TGT_B:   tgt_full = full_b;
         TGT_C:   tgt_full = full_c;
         default: tgt_full = 1'b1;
      endcase
   end

   // Pass-through payload: dx rewritten with dx+ADD, wrapping in DXW bits.
   always_comb begin
      head_adj                = head;
      head_adj[DX_MSB:DX_LSB] = head_dx + ADD_V;
   end

   // North/south payload: the dx field is removed and the remaining bits close up.
   generate
      if (DX_MSB == DATA_WIDTH - 1) begin : g_strip_top
         assign head_strip = head[DX_LSB-1:0];
      end else begin : g_strip_mid
         assign head_strip = {head[DATA_WIDTH-1:DX_MSB+1], head[DX_LSB-1:0]};
      end
   endgenerate

   // A write while full is dropped even if the head leaves in the same cycle.
   assign push = din_wen && !fifo_full;
   assign pop  = !fifo_empty && !tgt_full;

   // Pointer, occupancy and sticky overflow next-state.
   always_comb begin
      wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
      overflow_d = overflow_q | (din_wen & fifo_full);
      count_d    = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Output next-state: only the targeted port is reloaded and strobed.
   always_comb begin
      dout_a_d = dout_a_q;
      dout_b_d = dout_b_q;
      dout_c_d = dout_c_q;
      wen_a_d  = 1'b0;
      wen_b_d  = 1'b0;
      wen_c_d  = 1'b0;
      if (pop) begin
         case (head_tgt)
            TGT_A: begin
               dout_a_d = head_adj;
               wen_a_d  = 1'b1;
            end
            TGT_B: begin
               dout_b_d = head_strip;
               wen_b_d  = 1'b1;
            end
            TGT_C: begin
               dout_c_d = head_strip;
               wen_c_d  = 1'b1;
            end
            default: begin
               wen_a_d = 1'b0;
            end
         endcase
      end
   end

   // Packet storage: written on accepted pushes, deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= din;
      end
   end

   // Control and output registers; reset discards queued packets and pending strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         dout_a_q   <= '0;
         dout_b_q   <= '0;
         dout_c_q   <= '0;
         wen_a_q    <= 1'b0;
         wen_b_q    <= 1'b0;
         wen_c_q    <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         dout_a_q   <= dout_a_d;
         dout_b_q   <= dout_b_d;
         dout_c_q   <= dout_c_d;
         wen_a_q    <= wen_a_d;
         wen_b_q    <= wen_b_d;
         wen_c_q    <= wen_c_d;
      end
   end

   assign buffer_full = fifo_full;
   assign overflow    = overflow_q;
   assign dout_a      = dout_a_q;
   assign dout_b      = dout_b_q;
   assign dout_c      = dout_c_q;
   assign wen_a       = wen_a_q;
   assign wen_b       = wen_b_q;
   assign wen_c       = wen_c_q;

endmodule

// File: doc/forward_ew_buffered.md
# forward_ew_buffered

Buffered front end of a router's forward east / forward west path. Accepts spike packets from the local or adjacent router, stores them in a circular FIFO, decodes the head packet (dx adjust, north/south split by dy sign) and issues it on one of three registered outputs when that output's downstream buffer is not full. It sits directly upstream of, and feeds, the forward north/south stages and the east/west router output.

## Interface
- DATA_WIDTH, 32, packet width
- DX_MSB, 29, dx field MSB (signed two's complement)
- DX_LSB, 21, dx field LSB
- DY_MSB, 20, dy field MSB (signed two's complement)
- DY_LSB, 12, dy field LSB
- ADD, 1, value added to dx on pass-through (1 for west, -1 for east)
- BUFFER_DEPTH, 4, FIFO entries; power of two, >= 2
- Derived: DXW = DX_MSB-DX_LSB+1; AW = log2(BUFFER_DEPTH)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  DATA_WIDTH  incoming packet
- din_wen  in  1  write strobe for din
- buffer_full  out  1  FIFO holds BUFFER_DEPTH entries
- overflow  out  1  sticky: a write was dropped while full
- dout_a  out  DATA_WIDTH  pass-through packet, dx replaced by dx+ADD
- wen_a  out  1  write strobe for dout_a
- full_a  in  1  downstream of port a cannot accept
- dout_b  out  DATA_WIDTH-DXW  packet with dx field removed (dy >= 0)
- wen_b  out  1  write strobe for dout_b
- full_b  in  1  downstream of port b cannot accept
- dout_c  out  DATA_WIDTH-DXW  packet with dx field removed (dy < 0)
- wen_c  out  1  write strobe for dout_c
- full_c  in  1  downstream of port c cannot accept

## Operation
- FIFO: write pointer, read pointer (AW bits, wrap modulo BUFFER_DEPTH), count (AW+1 bits, 0..BUFFER_DEPTH).
- buffer_full = (count == BUFFER_DEPTH), from registered count only.
- Push: din_wen && !buffer_full -> mem[wptr] <= din, wptr++. din_wen && buffer_full -> packet dropped, overflow <= 1; stays 1 until reset. Dropping is not blocked by a same-cycle pop.
- Head decode, head = mem[rptr]: dx == 0 -> target c if dy < 0, else target b; dx != 0 -> target a.
- Pop: count != 0 && full_<target> == 0 -> rptr++, and the outputs are loaded on that edge.
- Only one pop per cycle. Blocked head stalls the whole FIFO; no bypass of a later packet.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Output register, loaded on a pop:
  - dout_a <= head with [DX_MSB:DX_LSB] replaced by dx+ADD, truncated to DXW bits (wraps, no saturation).
  - dout_b / dout_c <= head with the dx field removed: {head[DATA_WIDTH-1:DX_MSB+1], head[DX_LSB-1:0]}, upper part omitted when DX_MSB == DATA_WIDTH-1.
  - Only the targeted dout is loaded. The other two dout registers hold their value.
  - Exactly one of wen_a/b/c <= 1; the others <= 0.
- No pop in a cycle -> all wen_* <= 0 next cycle; dout_* hold.
- Downstream contract: full_x is sampled in the pop cycle. The issued write lands one cycle later, so the downstream must raise full_x with one entry of slack.

## Timing
- Reset (rst_n low, asynchronous): count, wptr, rptr, overflow, wen_a/b/c, dout_a/b/c all 0; buffer_full 0. FIFO memory is not cleared.
- Reset mid-operation discards every buffered packet and any pending wen. Outputs are 0 the cycle after release.
- Latency with empty FIFO and no backpressure: din_wen at edge N; count = 1 after N; pop at edge N+1; wen_x high for the cycle after N+1. That is 2 cycles, din_wen to wen.
- Sustained throughput: one packet per cycle when the target full_x stays low.
- buffer_full rises the cycle after the BUFFER_DEPTH-th accepted write. It falls the cycle after a pop that is not paired with a push.

## Test plan
- ADD=1, write din with dx=3, dy=0 -> 2 cycles later wen_a=1 for exactly one cycle, dout_a dx field = 4, all other bits equal to din; wen_b=wen_c=0.
- Write dx=0, dy=-2, then dx=0, dy=+5, back-to-back -> wen_c then wen_b on consecutive cycles; payloads are din with the dx field removed.
- ADD=-1, dx=0x1FF (-1) -> routed to a with dx=0x1FE; dx=1 -> routed to a with dx=0. Separately, ADD=1 with dx=0x1FF -> dx wraps to 0.
- Hold full_a=1, write 5 packets targeting a (BUFFER_DEPTH=4) -> buffer_full=1 after 4 writes, 5th dropped, overflow=1. Release full_a -> 4 packets out in order on 4 consecutive cycles, then buffer_full=0.
- Head blocked (target b, full_b=1) with the next entry targeting c -> no wen at all until full_b drops; then b is issued before c.
- Assert rst_n=0 asynchronously mid-stream with 3 entries queued -> all wen_*=0 and dout_*=0 immediately; after release no stale packet is emitted and overflow=0.
